// File: rtl/ws_sta_out_drain.sv
// ============================================================================
// Module   : ws_sta_out_drain
// Purpose  : Ping-pong snapshot capture of array output columns with deskewed
//            group sampling, drained as GROUP-column beats over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws_sta_out_drain #(
    parameter int N_COLS = 64,
    parameter int C_W    = 20,
    parameter int GROUP  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_COLS*C_W-1:0]   io_outputC,
    input  logic                    io_start,
    output logic                    io_start_ready,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [GROUP*C_W-1:0]    io_out_data,
    output logic [3:0]              io_out_index,
    output logic                    io_out_last,
    output logic                    io_drop
);

    localparam int         BEAT_W   = GROUP * C_W;
    localparam logic [3:0] LAST_GRP = 4'(N_COLS / GROUP - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_t;

    cap_state_t             state, state_nxt;
    logic [3:0]             cap_grp, cap_grp_nxt;
    logic                   cap_wr, cap_done, start_ok;
    logic [1:0]             full, full_nxt;
    logic                   wr_ptr, rd_ptr;
    logic [3:0]             rd_beat;
    logic                   xfer, drain_done;
    logic [N_COLS*C_W-1:0]  snap [2];

    assign io_start_ready = (state == IDLE) && !full[wr_ptr];
    assign start_ok       = io_start && io_start_ready;

    // Group g is written one cycle after group g-1, absorbing the array skew.
    always_comb begin
        state_nxt   = state;
        cap_grp_nxt = cap_grp;
        cap_wr      = 1'b0;
        cap_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    cap_wr      = 1'b1;
                    cap_grp_nxt = 4'd1;
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_wr = 1'b1;
                if (cap_grp == LAST_GRP) begin
                    cap_done    = 1'b1;
                    cap_grp_nxt = 4'd0;
                    state_nxt   = IDLE;
                end else begin
                    cap_grp_nxt = cap_grp + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cap_grp <= 4'd0;
        end else begin
            state   <= state_nxt;
            cap_grp <= cap_grp_nxt;
        end
    end

    // Snapshot storage carries no reset; validity lives in the full flags.
    always_ff @(posedge clock) begin
        if (cap_wr) begin
            snap[wr_ptr][int'(cap_grp)*BEAT_W +: BEAT_W] <=
                io_outputC[int'(cap_grp)*BEAT_W +: BEAT_W];
        end
    end

    assign xfer       = io_out_valid && io_out_ready;
    assign drain_done = xfer && (rd_beat == LAST_GRP);

    // Capture fills the write buffer while drain empties the read buffer, so
    // simultaneous completion always touches different flags.
    always_comb begin
        full_nxt = full;
        if (cap_done)   full_nxt[wr_ptr] = 1'b1;
        if (drain_done) full_nxt[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full    <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            rd_beat <= 4'd0;
            io_drop <= 1'b0;
        end else begin
            full <= full_nxt;
            if (cap_done)
                wr_ptr <= !wr_ptr;
            if (drain_done) begin
                rd_ptr  <= !rd_ptr;
                rd_beat <= 4'd0;
            end else if (xfer) begin
                rd_beat <= rd_beat + 4'd1;
            end
            if (io_start && !io_start_ready)
                io_drop <= 1'b1;
        end
    end

    assign io_out_valid = full[rd_ptr];
    assign io_out_data  = io_out_valid ? snap[rd_ptr][int'(rd_beat)*BEAT_W +: BEAT_W]
                                       : '0;
    assign io_out_index = io_out_valid ? rd_beat : 4'd0;
    assign io_out_last  = io_out_valid && (rd_beat == LAST_GRP);

endmodule

`default_nettype wire

// File: tb/tb_ws_sta_out_drain.sv
// ============================================================================
// Module   : tb_ws_sta_out_drain
// Purpose  : Randomized and directed checks of ws_sta_out_drain against a
//            snapshot-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws_sta_out_drain;

    localparam int N_COLS = 64;
    localparam int C_W    = 20;
    localparam int GROUP  = 4;
    localparam int BW     = GROUP * C_W;
    localparam int SW     = N_COLS * C_W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [SW-1:0]   io_outputC = '0;
    logic            io_start = 1'b0;
    logic            io_start_ready;
    logic            io_out_valid;
    logic            io_out_ready = 1'b0;
    logic [BW-1:0]   io_out_data;
    logic [3:0]      io_out_index;
    logic            io_out_last;
    logic            io_drop;

    ws_sta_out_drain #(.N_COLS(N_COLS), .C_W(C_W), .GROUP(GROUP)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_outputC     (io_outputC),
        .io_start       (io_start),
        .io_start_ready (io_start_ready),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_data    (io_out_data),
        .io_out_index   (io_out_index),
        .io_out_last    (io_out_last),
        .io_drop        (io_drop)
    );

    always #5 clock = !clock;

    // Reference model: completed snapshots waiting to drain, plus one in flight.
    logic [SW-1:0] snap_q[$];
    logic [SW-1:0] cap_vec;
    logic [SW-1:0] cols;
    bit            capturing;
    int            cap_g;
    int            m_beat;
    bit            m_drop;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        snap_q.delete();
        capturing = 0;
        cap_g     = 0;
        m_beat    = 0;
        m_drop    = 0;
    endtask

    // One clock: compare outputs, apply inputs, advance model, move to next negedge.
    task automatic step(input logic st, input logic rdy);
        bit            exp_valid;
        bit            m_ready;
        logic [BW-1:0] exp_data;
        exp_valid = snap_q.size() > 0;
        m_ready   = !capturing && snap_q.size() < 2;
        exp_data  = exp_valid ? snap_q[0][m_beat*BW +: BW] : '0;
        check("valid", io_out_valid, exp_valid);
        check("data",  io_out_data, exp_data);
        check("index", io_out_index, exp_valid ? m_beat : 0);
        check("last",  io_out_last, exp_valid && m_beat == 15);
        check("start_ready", io_start_ready, m_ready);
        check("drop",  io_drop, m_drop);

        io_start     = st;
        io_out_ready = rdy;
        io_outputC   = cols;

        if (st && !m_ready) m_drop = 1;
        if (exp_valid && rdy) begin
            if (m_beat == 15) begin
                void'(snap_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (capturing) begin
            cap_vec[cap_g*BW +: BW] = cols[cap_g*BW +: BW];
            if (cap_g == 15) begin
                snap_q.push_back(cap_vec);
                capturing = 0;
            end else begin
                cap_g++;
            end
        end else if (st && m_ready) begin
            cap_vec            = '0;
            cap_vec[0 +: BW]   = cols[0 +: BW];
            capturing          = 1;
            cap_g              = 1;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        io_start = 1'b0;
        #1;
        check("rst_valid", io_out_valid, 1'b0);
        check("rst_data",  io_out_data, '0);
        check("rst_index", io_out_index, 4'd0);
        check("rst_last",  io_out_last, 1'b0);
        check("rst_drop",  io_drop, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic fill_cols_count();
        for (int k = 0; k < N_COLS; k++) cols[k*C_W +: C_W] = 20'(cyc);
    endtask

    task automatic fill_cols_rand();
        for (int k = 0; k < N_COLS; k++) cols[k*C_W +: C_W] = 20'($urandom);
    endtask

    initial begin
        model_clear();
        cols = '0;
        @(negedge clock);
        do_reset();

        // Single snapshot with fixed column values
        for (int k = 0; k < N_COLS; k++) cols[k*C_W +: C_W] = 20'(32'h100 + k);
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        do_reset();

        // Deskew: columns carry the cycle count
        for (int i = 0; i < 36; i++) begin
            fill_cols_count();
            step(i == 0, 1'b1);
        end
        do_reset();

        // Backpressure on beat 7 (visible at step 23)
        fill_cols_rand();
        for (int i = 0; i < 40; i++) step(i == 0, !(i >= 23 && i <= 27));
        do_reset();

        // Overflow: two accepted, third dropped, then drain 32 beats
        for (int i = 0; i < 34; i++) begin
            fill_cols_rand();
            step(i == 0 || i == 16 || i == 32, 1'b0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        do_reset();

        // Back-to-back snapshots
        for (int i = 0; i < 50; i++) begin
            fill_cols_rand();
            step(i == 0 || i == 16, 1'b1);
        end
        do_reset();

        // Reset in the middle of a drain, then confirm nothing stale appears
        fill_cols_rand();
        for (int i = 0; i < 23; i++) step(i == 0, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            fill_cols_rand();
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
